score_bcd: RTL and testbench
============================

# score_bcd

Sequential binary-to-BCD converter that turns the game's binary score into four BCD digits for the 4-digit seven-segment display driver, which sits directly downstream. It accepts a 14-bit score on a start pulse, runs an iterative shift-and-add-3 (double dabble), and updates its registered digit outputs only on completion. Between conversions the digits hold steady, so the display never sees partial values.

## Interface
- BIN_W, 14, width of the binary input
- MAX_VAL, 9999, largest displayable value; larger inputs saturate to this value
- clk_100MHz  in  1  system clock; one clock only
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- bin_in  in  BIN_W  binary score; sampled on the accepting edge only
- busy  out  1  high whenever state is not IDLE
- done  out  1  single-cycle pulse; digit outputs are valid from this cycle onward
- overflow  out  1  last conversion saturated (bin_in > MAX_VAL)
- ones, tens, hundreds, thousands  out  4 each  BCD digits (0..9), registered

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - On start: capture bin_in.
    - If bin_in > MAX_VAL, load MAX_VAL into the binary half of the scratch register and set ovf_pend; otherwise load bin_in and clear ovf_pend.
  - Clear the BCD half of the scratch register, set cnt=0, go to SHIFT.
- **SHIFT** (one iteration per cycle)
  - For each of the 4 BCD nibbles: if the nibble is ≥5, add 3.
  - Then shift the whole 16+BIN_W-bit scratch register left by 1, moving the binary MSB into the BCD LSB.
  - cnt increments each iteration. The iteration where cnt==BIN_W-1 is the last one; after it, go to DONE.
  - There is no add-3 correction after the final shift.
- **DONE**
  - Copy the scratch BCD nibbles to the thousands/hundreds/tens/ones output registers.
  - Copy ovf_pend to overflow.
  - Pulse done for this one cycle, then go to IDLE.
- Width rules:
  - cnt is 4 bits.
  - Nibble add-3 is 4-bit and never carries, because the input is ≤4'd9 before correction.
  - The saturation compare uses the full BIN_W bits.
- start while busy is ignored entirely; no queueing.
- Reset, including reset mid-conversion:
  - State goes to IDLE; scratch register and cnt are cleared.
  - All digit outputs = 0, overflow = 0, done = 0, busy = 0.
  - An aborted conversion never produces done.

## Timing
- start sampled high at edge k:
  - SHIFT iterations on edges k+1 … k+BIN_W.
  - DONE state active on edge k+BIN_W+1; outputs and done are updated there.
- With BIN_W=14:
  - done is high for exactly one cycle, after edge k+15.
  - busy is high for the 15 cycles after edges k … k+14.
  - busy is low in the done cycle, since state has returned to IDLE.
- busy is decoded from the state register (state ≠ IDLE). done is a registered pulse.
- Back-to-back: a start asserted in the cycle where done is high is accepted (state is IDLE). Maximum throughput is one conversion per 16 cycles.
- Digit outputs change only at the DONE edge or on reset. The display driver may sample them asynchronously to this block's handshake.

## Structure
- Shared package score_pkg holds:
  - BIN_W and MAX_VAL defaults
  - the state enum {IDLE, SHIFT, DONE}
  - the BCD nibble width constant
- One sub-module, bcd_add3: combinational 4-bit conditional add-3 correction (nibble ≥5 → +3). Instantiate it 4 times.
- The top level holds the FSM, cnt, the scratch shift register and the output registers.

## Test plan
- Reset, then start with bin_in=0 → done pulses exactly 15 cycles after the accepting edge; digits 0/0/0/0; overflow=0; busy high for exactly 15 cycles.
- bin_in=1234 → thousands=1, hundreds=2, tens=3, ones=4 at done; digits unchanged for 100 idle cycles afterwards.
- bin_in=9999 → 9/9/9/9 with overflow=0.
  - Then bin_in=12000 → 9/9/9/9 with overflow=1.
  - Then bin_in=42 → 0/0/4/2 with overflow=0.
- start with bin_in=305, then pulse start at k+3 and k+14 with bin_in=777 → both extra pulses ignored; a single done with 0/3/0/5.
- bin_in=5, then start with 678 in the same cycle that done is high → second conversion accepted; done again 15 cycles later with 0/6/7/8.
- Convert 4321, then start 8888 and assert rst at k+7 → next cycle: digits 0/0/0/0, busy=0, no done. A fresh start with 60 yields 0/0/6/0.

Source files
------------

// File: rtl/score_bcd_pkg.sv
// Shared constants and state type for the score binary-to-BCD converter.
// Both the converter and its bus interface import this package.
package score_pkg;

  localparam int BIN_W_DEF   = 14;
  localparam int MAX_VAL_DEF = 9999;
  localparam int NIB_W       = 4;
  localparam int NUM_DIGITS  = 4;
  localparam int BCD_W       = NIB_W * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/score_bcd_if.sv
// Request/result bundle between the score source and the BCD converter.
// Handshake: start is a one-cycle request honoured only while busy is low; done
// pulses once per accepted request and the digits stay valid until the next done.
interface score_bcd_if #(
  parameter int BIN_W = score_pkg::BIN_W_DEF
) ();

  logic                                 start;
  logic [BIN_W-1:0]                     bin_in;
  logic                                 busy;
  logic                                 done;
  logic                                 overflow;
  logic [score_pkg::NIB_W-1:0]          ones;
  logic [score_pkg::NIB_W-1:0]          tens;
  logic [score_pkg::NIB_W-1:0]          hundreds;
  logic [score_pkg::NIB_W-1:0]          thousands;
  score_pkg::state_e                    state_dbg;

  modport master (
    output start, bin_in,
    input  busy, done, overflow, ones, tens, hundreds, thousands, state_dbg
  );

  modport slave (
    input  start, bin_in,
    output busy, done, overflow, ones, tens, hundreds, thousands, state_dbg
  );

endinterface

// File: rtl/score_bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3
  import score_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [NIB_W-1:0] nib_o
);

  // Inputs are at most 9, so the sum fits in 4 bits and never carries.
  always_comb begin
    nib_o = nib_i;
    if (nib_i >= 4'd5) begin
      nib_o = nib_i + 4'd3;
    end
  end

endmodule

// File: rtl/score_bcd.sv
// Iterative binary-to-BCD converter for the 4-digit score display.
// Digits and overflow are registered and only change at completion or reset.
module score_bcd
  import score_pkg::*;
#(
  parameter int BIN_W   = BIN_W_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  score_bcd_if.slave  bus
);

  localparam int               SCR_W    = BCD_W + BIN_W;
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
  localparam logic [3:0]       CNT_LAST = 4'(BIN_W - 1);

  state_e             state_q,    state_d;
  logic [SCR_W-1:0]   scratch_q,  scratch_d;
  logic [3:0]         cnt_q,      cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   digits_q,   digits_d;
  logic               overflow_q, overflow_d;
  logic               done_q,     done_d;

  logic [BCD_W-1:0]   bcd_cur;
  logic [BCD_W-1:0]   bcd_corr;
  logic               sat;

  assign bcd_cur = scratch_q[SCR_W-1 -: BCD_W];
  assign sat     = (bus.bin_in > MAX_BIN);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (bcd_cur [i*NIB_W +: NIB_W]),
      .nib_o (bcd_corr[i*NIB_W +: NIB_W])
    );
  end

  always_comb begin
    state_d    = state_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          scratch_d  = {{BCD_W{1'b0}}, (sat ? MAX_BIN : bus.bin_in)};
          ovf_pend_d = sat;
          cnt_d      = 4'd0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        // Correct first, then shift; the final shift is left uncorrected.
        scratch_d = {bcd_corr, scratch_q[BIN_W-1:0]} << 1;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end

      DONE: begin
        digits_d   = bcd_cur;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q    <= IDLE;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.overflow  = overflow_q;
  assign bus.thousands = digits_q[3*NIB_W +: NIB_W];
  assign bus.hundreds  = digits_q[2*NIB_W +: NIB_W];
  assign bus.tens      = digits_q[1*NIB_W +: NIB_W];
  assign bus.ones      = digits_q[0*NIB_W +: NIB_W];
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_score_bcd.sv
// Bench for score_bcd: directed scenarios plus random scores, checked every
// cycle against a decimal-arithmetic model of accept timing and displayed value.
module tb_score_bcd;
  import score_pkg::*;

  localparam int BIN_W = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  score_bcd_if #(.BIN_W(BIN_W)) bus ();

  score_bcd #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
    .clk_100MHz (clk),
    .rst        (rst),
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  logic [16:0] exp_q[$];
  logic [16:0] disp_exp  = '0;
  int          acc_last  = -100;
  int          free_edge = 0;
  bit          mon_en    = 1'b0;
  int          n_checks  = 0;
  int          n_err     = 0;

  function automatic logic [16:0] ref_model(input int v);
    int  s;
    logic sat;
    sat = (v > 9999);
    s   = sat ? 9999 : v;
    return {sat, 4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input int val);
    int e;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = BIN_W'(val);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e = cyc;
    if (e >= free_edge) begin
      acc_last  = e;
      free_edge = e + 16;
      exp_q.push_back(ref_model(val));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    acc_last  = -100;
    free_edge = 0;
    disp_exp  = '0;
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic   busy_exp;
      logic   done_exp;
      state_e st_exp;
      busy_exp = (cyc >= acc_last) && (cyc <= acc_last + 14);
      done_exp = (cyc == acc_last + 15);
      st_exp   = !busy_exp ? IDLE : ((cyc == acc_last + 14) ? DONE : SHIFT);
      if (done_exp) begin
        if (exp_q.size() == 0) check("exp_q_underflow", 32'd1, 32'd0);
        else disp_exp = exp_q.pop_front();
      end
      check("busy", 32'(bus.busy), 32'(busy_exp));
      check("done", 32'(bus.done), 32'(done_exp));
      check("state", 32'(bus.state_dbg), 32'(st_exp));
      check("digits", {16'h0, bus.thousands, bus.hundreds, bus.tens, bus.ones},
            {16'h0, disp_exp[15:0]});
      check("overflow", 32'(bus.overflow), 32'(disp_exp[16]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.start  = 1'b0;
    bus.bin_in = '0;
    idle(3);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    issue(0);      idle(20);
    issue(1234);   idle(116);
    issue(9999);   idle(20);
    issue(12000);  idle(20);
    issue(42);     idle(20);

    // extra starts at k+3 and k+14 must be dropped
    issue(305);
    idle(2);  issue(777);
    idle(10); issue(777);
    idle(20);

    // second start lands in the done cycle
    issue(5);
    idle(15); issue(678);
    idle(20);

    // reset aborts a conversion in flight
    issue(4321);   idle(20);
    issue(8888);
    idle(6);  do_reset();
    idle(20);
    issue(60);     idle(20);

    for (int i = 0; i < 40; i++) begin
      int v;
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(9990, 16383) : $urandom_range(0, 9999);
      issue(v);
      idle($urandom_range(0, 20));
    end
    issue(16383);  idle(20);
    issue(10000);  idle(20);
    issue(9998);   idle(20);

    check("pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
